// File: rtl/demux_nline_reg.sv
// demux_nline_reg: registered 1-to-NOUT demultiplexer with valid/ready handshakes.
// Each output channel owns a one-entry holding register, so a stalled consumer
// only ever blocks words addressed to its own channel. Idle channels drive zero.
// Optional broadcast mode is enabled by defining DEMUX_BCAST_EN, which adds the
// in_bcast input; without it the logic behaves as if in_bcast were tied low.
module demux_nline_reg #(
    parameter int WIDTH = 8,
    parameter int NOUT  = 4,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  clr_n,
`ifdef DEMUX_BCAST_EN
    input  logic                  in_bcast,
`endif
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NOUT*WIDTH-1:0] out_data,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready,
    output logic                  sel_err
);

    // One extra bit so the range compare cannot wrap when 2**SEL_W == NOUT.
    localparam logic [SEL_W:0] NOUT_L = (SEL_W + 1)'(NOUT);

    logic                        bcast;
    logic [NOUT-1:0]             free;
    logic                        sel_ok;
    logic                        sel_free;
    logic                        all_free;
    logic                        accept;
    logic [NOUT-1:0]             load;

    logic [NOUT-1:0][WIDTH-1:0]  data_p1;
    logic [NOUT-1:0]             vld_p1;
    logic                        err_p1;

`ifdef DEMUX_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    // A channel can take a word when it is empty or is being emptied this cycle.
    assign free   = ~vld_p1 | out_ready;
    assign sel_ok = ({1'b0, in_sel} < NOUT_L);

    // Look up the addressed channel's free flag without indexing past NOUT.
    always_comb begin
        sel_free = 1'b0;
        for (int k = 0; k < NOUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_free = free[k];
            end
        end
    end

    assign all_free = &free;

    // Out-of-range words are always taken (and dropped); broadcast needs every channel.
    assign in_ready = bcast ? all_free : (sel_ok ? sel_free : 1'b1);
    assign accept   = in_valid && in_ready;

    // Per-channel load strobe: the addressed channel, or all of them on broadcast.
    always_comb begin
        load = '0;
        for (int k = 0; k < NOUT; k++) begin
            load[k] = accept && (bcast || (in_sel == SEL_W'(k)));
        end
    end

    // Stage p1: holding registers; refill wins over drain, drain clears data to zero.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            data_p1 <= '0;
            vld_p1  <= '0;
            err_p1  <= 1'b0;
        end else begin
            err_p1 <= accept && !bcast && !sel_ok;
            for (int k = 0; k < NOUT; k++) begin
                if (load[k]) begin
                    data_p1[k] <= in_data;
                    vld_p1[k]  <= 1'b1;
                end else if (vld_p1[k] && out_ready[k]) begin
                    data_p1[k] <= '0;
                    vld_p1[k]  <= 1'b0;
                end
            end
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign sel_err   = err_p1;

endmodule

// File: tb/tb_demux_nline_reg.sv
// Directed testbench for demux_nline_reg: a 4-channel instance driven from a
// vector table plus hand sequences, and a 3-channel instance for out-of-range selects.
module tb_demux_nline_reg;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;

    // 4-channel instance
    logic [7:0]  d4 = '0;
    logic [1:0]  sel4 = '0;
    logic        iv4 = 1'b0;
    logic        bc4 = 1'b0;
    logic        rdy4;
    logic [31:0] od4;
    logic [3:0]  ov4;
    logic [3:0]  ordy4 = 4'hF;
    logic        se4;

    // 3-channel instance
    logic [7:0]  d3 = '0;
    logic [1:0]  sel3 = '0;
    logic        iv3 = 1'b0;
    logic        bc3 = 1'b0;
    logic        rdy3;
    logic [23:0] od3;
    logic [2:0]  ov3;
    logic [2:0]  ordy3 = 3'b111;
    logic        se3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux_nline_reg #(.WIDTH(8), .NOUT(4), .SEL_W(2)) u4 (
        .clk(clk), .clr_n(clr_n),
`ifdef DEMUX_BCAST_EN
        .in_bcast(bc4),
`endif
        .in_data(d4), .in_sel(sel4), .in_valid(iv4), .in_ready(rdy4),
        .out_data(od4), .out_valid(ov4), .out_ready(ordy4), .sel_err(se4)
    );

    demux_nline_reg #(.WIDTH(8), .NOUT(3), .SEL_W(2)) u3 (
        .clk(clk), .clr_n(clr_n),
`ifdef DEMUX_BCAST_EN
        .in_bcast(bc3),
`endif
        .in_data(d3), .in_sel(sel3), .in_valid(iv3), .in_ready(rdy3),
        .out_data(od3), .out_valid(ov3), .out_ready(ordy3), .sel_err(se3)
    );

    // Producer must hold a stalled word unchanged until it is taken.
    a_hold: assert property (@(posedge clk) disable iff (!clr_n)
        (iv4 && !rdy4) |=> (iv4 && d4 == $past(d4) && sel4 == $past(sel4) && bc4 == $past(bc4)))
        else begin
            bad++;
            $display("FAIL producer_hold: stalled word changed before acceptance");
        end

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        erdy;
        logic [3:0]  eov;
        logic [31:0] eod;
    } vec_t;

    vec_t tv[20];

    function automatic vec_t mk(logic iv, logic [1:0] sel, logic [7:0] d, logic [3:0] ordy,
                                logic erdy, logic [3:0] eov, logic [31:0] eod);
        vec_t v;
        v.iv = iv; v.sel = sel; v.d = d; v.ordy = ordy;
        v.erdy = erdy; v.eov = eov; v.eod = eod;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Stimulus table: inputs for a cycle, plus in_ready and the registered
        // outputs expected at mid-cycle of that same cycle.
        tv[0]  = mk(0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 32'h00000000);
        tv[1]  = mk(0, 2'd3, 8'h00, 4'hF, 1, 4'b0000, 32'h00000000);
        tv[2]  = mk(1, 2'd2, 8'hA5, 4'hF, 1, 4'b0000, 32'h00000000);
        tv[3]  = mk(0, 2'd0, 8'h00, 4'hF, 1, 4'b0100, 32'h00A50000);
        tv[4]  = mk(0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 32'h00000000);
        tv[5]  = mk(1, 2'd1, 8'h11, 4'hD, 1, 4'b0000, 32'h00000000);
        tv[6]  = mk(1, 2'd1, 8'h22, 4'hD, 0, 4'b0010, 32'h00001100);
        tv[7]  = mk(1, 2'd1, 8'h22, 4'hD, 0, 4'b0010, 32'h00001100);
        tv[8]  = mk(1, 2'd1, 8'h22, 4'hF, 1, 4'b0010, 32'h00001100);
        tv[9]  = mk(0, 2'd1, 8'h00, 4'hD, 0, 4'b0010, 32'h00002200);
        tv[10] = mk(1, 2'd0, 8'h33, 4'hC, 1, 4'b0010, 32'h00002200);
        tv[11] = mk(1, 2'd3, 8'h44, 4'hC, 1, 4'b0011, 32'h00002233);
        tv[12] = mk(0, 2'd0, 8'h00, 4'hC, 0, 4'b1011, 32'h44002233);
        tv[13] = mk(0, 2'd3, 8'h00, 4'hC, 1, 4'b0011, 32'h00002233);
        tv[14] = mk(0, 2'd0, 8'h00, 4'hF, 1, 4'b0011, 32'h00002233);
        tv[15] = mk(0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 32'h00000000);
        tv[16] = mk(1, 2'd2, 8'h01, 4'hF, 1, 4'b0000, 32'h00000000);
        tv[17] = mk(1, 2'd2, 8'h02, 4'hF, 1, 4'b0100, 32'h00010000);
        tv[18] = mk(0, 2'd0, 8'h00, 4'hF, 1, 4'b0100, 32'h00020000);
        tv[19] = mk(0, 2'd0, 8'h00, 4'hF, 1, 4'b0000, 32'h00000000);

        // Reset held for three cycles, released away from the edge.
        repeat (3) @(posedge clk);
        #1 clr_n = 1'b1;
        @(negedge clk);
        chk("reset_ov4", {28'd0, ov4}, 32'd0);
        chk("reset_od4", od4, 32'd0);
        chk("reset_se4", {31'd0, se4}, 32'd0);
        chk("reset_ov3", {29'd0, ov3}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            to_drive();
            iv4 = tv[i].iv; sel4 = tv[i].sel; d4 = tv[i].d; ordy4 = tv[i].ordy;
            @(negedge clk);
            chk($sformatf("tv%0d_rdy", i), {31'd0, rdy4}, {31'd0, tv[i].erdy});
            chk($sformatf("tv%0d_ov", i), {28'd0, ov4}, {28'd0, tv[i].eov});
            chk($sformatf("tv%0d_od", i), od4, tv[i].eod);
            chk($sformatf("tv%0d_se", i), {31'd0, se4}, 32'd0);
        end
        to_drive();
        iv4 = 1'b0; sel4 = 2'd0; d4 = 8'h00; ordy4 = 4'hF;

        // Out-of-range select on the 3-channel instance while channel 2 is stalled.
        iv3 = 1'b1; sel3 = 2'd2; d3 = 8'h77; ordy3 = 3'b011;
        @(negedge clk);
        chk("oor_load_rdy", {31'd0, rdy3}, 32'd1);
        to_drive();
        iv3 = 1'b1; sel3 = 2'd3; d3 = 8'hFF;
        @(negedge clk);
        chk("oor_rdy", {31'd0, rdy3}, 32'd1);
        chk("oor_ov_before", {29'd0, ov3}, 32'h4);
        chk("oor_od_before", {8'd0, od3}, 32'h00770000);
        chk("oor_se_before", {31'd0, se3}, 32'd0);
        to_drive();
        iv3 = 1'b0; sel3 = 2'd0; d3 = 8'h00;
        @(negedge clk);
        chk("oor_se_pulse", {31'd0, se3}, 32'd1);
        chk("oor_ov_kept", {29'd0, ov3}, 32'h4);
        chk("oor_od_kept", {8'd0, od3}, 32'h00770000);
        to_drive();
        ordy3 = 3'b111;
        @(negedge clk);
        chk("oor_se_end", {31'd0, se3}, 32'd0);
        to_drive();
        @(negedge clk);
        chk("oor_drained", {29'd0, ov3}, 32'd0);

`ifdef DEMUX_BCAST_EN
        // Broadcast to all-free channels, then a second broadcast blocked by channel 0.
        to_drive();
        bc4 = 1'b1; iv4 = 1'b1; d4 = 8'h5A; ordy4 = 4'b1110;
        @(negedge clk);
        chk("bc_rdy_free", {31'd0, rdy4}, 32'd1);
        to_drive();
        d4 = 8'hC3;
        @(negedge clk);
        chk("bc_ov", {28'd0, ov4}, 32'hF);
        chk("bc_od", od4, 32'h5A5A5A5A);
        chk("bc_rdy_blocked", {31'd0, rdy4}, 32'd0);
        to_drive();
        ordy4 = 4'hF;
        @(negedge clk);
        chk("bc_rdy_drain", {31'd0, rdy4}, 32'd1);
        to_drive();
        bc4 = 1'b0; iv4 = 1'b0; d4 = 8'h00;
        @(negedge clk);
        chk("bc_ov2", {28'd0, ov4}, 32'hF);
        chk("bc_od2", od4, 32'hC3C3C3C3);
        chk("bc_se", {31'd0, se4}, 32'd0);
        to_drive();
        @(negedge clk);
        chk("bc_drained", {28'd0, ov4}, 32'd0);
`endif

        // Asynchronous reset mid-cycle with channels 1 and 2 stalled.
        to_drive();
        iv4 = 1'b1; sel4 = 2'd1; d4 = 8'hB1; ordy4 = 4'b1001;
        to_drive();
        sel4 = 2'd2; d4 = 8'hB2;
        to_drive();
        iv4 = 1'b0; sel4 = 2'd0; d4 = 8'h00;
        @(negedge clk);
        chk("arst_pre_ov", {28'd0, ov4}, 32'h6);
        chk("arst_pre_od", od4, 32'h00B2B100);
        #2 clr_n = 1'b0;
        #1;
        chk("arst_ov", {28'd0, ov4}, 32'd0);
        chk("arst_od", od4, 32'd0);
        chk("arst_se", {31'd0, se4}, 32'd0);
        #1 clr_n = 1'b1;
        @(negedge clk);
        chk("arst_post_ov", {28'd0, ov4}, 32'd0);
        chk("arst_post_rdy", {31'd0, rdy4}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
